// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter: direction encoding and
// default parameter values.
package counter_pkg;
  localparam logic            DIR_UP       = 1'b1;
  localparam logic            DIR_DN       = 1'b0;
  localparam int              DEF_WIDTH    = 4;
  localparam longint unsigned DEF_MOD      = 10;
  localparam int              DEF_PRESCALE = 1;
endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: tick is high on every PRESCALE-th enabled cycle.
// The phase holds while en=0 and restarts on rst or clr.
module tick_prescaler #(
  parameter int PRESCALE = counter_pkg::DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ph_q, ph_d;

  assign tick = en && (ph_q == LAST);

  always_comb begin
    ph_d = ph_q;
    if (clr)       ph_d = '0;
    else if (tick) ph_d = '0;
    else if (en)   ph_d = ph_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ph_q <= '0;
    else     ph_q <= ph_d;
  end
endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MOD counter with prescaled steps, load, tc pulse and sticky
// wrapped flag. Define COUNTER_SATURATE_EN to saturate instead of wrapping.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = DEF_WIDTH,
  parameter longint unsigned MOD      = DEF_MOD,
  parameter int              PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;
  logic             tick;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    wrapped_d = wrapped_q;
    if (load) begin
      // Out-of-range loads clamp to the top of the range.
      count_d   = (64'(load_val) >= MOD) ? MAXV : load_val;
      wrapped_d = 1'b0;
    end else if (tick) begin
      if (up_dn == DIR_UP) begin
        if (count_q == MAXV) begin
          tc_d      = 1'b1;
          wrapped_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d   = count_q;
`else
          count_d   = '0;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d      = 1'b1;
          wrapped_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d   = count_q;
`else
          count_d   = MAXV;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign wrapped = wrapped_q;
endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH SHALL default to 4: count width in bits, legal range 1..32.
REQ-003 Parameter MOD SHALL default to 10: modulus, so count spans 0..MOD-1; legal range 2..2^WIDTH.
REQ-004 Parameter PRESCALE SHALL default to 1: enabled cycles per count step, legal range 1..65535.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port en  input  1  count enable; also gates the prescaler.
REQ-008 Port up_dn  input  1  direction: 1 = up, 0 = down; sampled on each step.
REQ-009 Port load  input  1  synchronous parallel load strobe.
REQ-010 Port load_val  input  WIDTH  value to load.
REQ-011 Port count  output  WIDTH  registered counter value.
REQ-012 Port tc  output  1  registered terminal-count pulse, one cycle per boundary event.
REQ-013 Port wrapped  output  1  registered sticky flag: at least one boundary event since the last reset or load.

Function
REQ-014 Priority SHALL be rst > load > step; at most one action per cycle.
REQ-015 A step SHALL occur only in a cycle with en=1 and the prescaler tick high; the tick SHALL be high on every PRESCALE-th enabled cycle, so PRESCALE=1 gives a step on every en=1 cycle.
REQ-016 The prescaler SHALL hold its phase while en=0 and SHALL restart its phase on load or rst.
REQ-017 Up step: count SHALL become count+1, or 0 when count==MOD-1 (boundary event).
REQ-018 Down step: count SHALL become count-1, or MOD-1 when count==0 (boundary event).
REQ-019 On a boundary event, tc SHALL be 1 in the cycle after the clock edge that performs the event, coincident with the new count; in all other cycles tc SHALL be 0.
REQ-020 On a boundary event, wrapped SHALL set to 1 and stay set until rst or load.
REQ-021 Load SHALL set count to load_val, or to MOD-1 when load_val>=MOD; tc SHALL be 0 and wrapped SHALL be 0 in the cycle that follows.
REQ-022 Load asserted together with en SHALL load and SHALL not step.
REQ-023 A change of up_dn between steps SHALL take effect on the next step with no extra latency.
REQ-024 Count arithmetic SHALL be modular at MOD, never at 2^WIDTH, and count SHALL never leave 0..MOD-1.

Reset
REQ-025 With rst=1 at a clock edge, count, tc, wrapped and the prescaler phase SHALL all be 0 after that edge, regardless of en and load.
REQ-026 Reset asserted mid-count SHALL abandon any partial prescaler interval.

Configuration
REQ-027 Macro COUNTER_SATURATE_EN, when defined, SHALL replace wrap with saturation. An up step at MOD-1 or a down step at 0 SHALL leave count unchanged, SHALL pulse tc, and SHALL set wrapped.
REQ-028 Without COUNTER_SATURATE_EN, wrap behaviour per REQ-017/018 SHALL apply.

Structure
REQ-029 Shared package counter_pkg SHALL hold the direction constants DIR_UP=1 and DIR_DN=0 and the default values for WIDTH, MOD and PRESCALE.
REQ-030 The prescaler SHALL be a sub-module named tick_prescaler, with ports clk, rst, en, clr and tick, parametrised by PRESCALE.

Verification (WIDTH=4, MOD=10, PRESCALE=1 unless stated)
REQ-031 Reset then en=1, up_dn=1 for 12 cycles -> count goes 1..9,0,1,2; tc is high exactly once, when count shows 0; wrapped is 1 afterwards.
REQ-032 load=1, load_val=2, then en=1, up_dn=0 for 4 cycles -> count 2,1,0,9,8; tc is high when count is 9.
REQ-033 load_val=13 with load=1 -> count=9; load together with en=1 -> count equals the loaded value and no step occurs.
REQ-034 PRESCALE=3, en=1 for 9 cycles, en=0 for 2 cycles mid-run -> count advances once per 3 enabled cycles and holds while en=0.
REQ-035 rst=1 at count=6 with en=1 and load=1 -> next cycle count=0, tc=0, wrapped=0.
REQ-036 With COUNTER_SATURATE_EN, count=9 and 3 up steps -> count stays 9 and tc pulses on each step.
